// File: rtl/and_4_bit_bist.sv
// Built-in self-test sequencer for a bitwise AND gate.
// Sweeps every operand pair, checks c against a & b, logs the first failure.
module and_4_bit_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic [WIDTH-1:0]   dut_c,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [WIDTH-1:0]   fail_c
);

    localparam int VW = 2 * WIDTH;
    localparam int CW = VW + 1;
    localparam logic [3:0] SLOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   v_q, v_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [CW-1:0]   err_q, err_d;
    logic [CW-1:0]   err_nx;
    logic            fv_q, fv_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [WIDTH-1:0] fc_q, fc_d;
    logic            mismatch;

    assign dut_a      = v_q[VW-1:WIDTH];
    assign dut_b      = v_q[WIDTH-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_c     = fc_q;

    assign mismatch = (dut_c != (dut_a & dut_b));

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fc_d    = fc_q;
        err_nx  = mismatch ? err_q + CW'(1) : err_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    v_d     = '0;
                    cnt_d   = SLOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                    fc_d    = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) state_d = S_CHECK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_CHECK: begin
                err_d = err_nx;
                if (mismatch && !fv_q) begin
                    fv_d = 1'b1;
                    fa_d = dut_a;
                    fb_d = dut_b;
                    fc_d = dut_c;
                end
                // all-ones vector is terminal; the counter never wraps
                if (&v_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_nx == '0);
                end else begin
                    state_d = S_SETTLE;
                    v_d     = v_q + VW'(1);
                    cnt_d   = SLOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fc_q    <= fc_d;
        end
    end

endmodule

// File: tb/tb_and_4_bit_bist.sv
// Directed bench for the AND-gate BIST sequencer.
// Gate models: correct, c[0] stuck-at-1, c forced to zero.
module tb_and_4_bit_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic [1:0] mode = 2'd0;

    logic [3:0] dut_a, dut_b, dut_c;
    logic       busy, done, pass, fail_valid;
    logic [8:0] err_count;
    logic [3:0] fail_a, fail_b, fail_c;

    logic [3:0] a3, b3, c3;
    logic       busy3, done3, pass3, fv3;
    logic [8:0] ec3;
    logic [3:0] fa3, fb3, fc3;

    int total = 0;
    int bad = 0;
    int edges;
    logic [8:0] ec_ref;

    always #5 clk = ~clk;

    assign dut_c = (mode == 2'd1) ? ((dut_a & dut_b) | 4'b0001) :
                   (mode == 2'd2) ? 4'b0000 : (dut_a & dut_b);
    assign c3 = a3 & b3;

    and_4_bit_bist #(.WIDTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid),
        .fail_a(fail_a), .fail_b(fail_b), .fail_c(fail_c)
    );

    and_4_bit_bist #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .dut_a(a3), .dut_b(b3), .dut_c(c3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(ec3), .fail_valid(fv3),
        .fail_a(fa3), .fail_b(fb3), .fail_c(fc3)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, count edges after the sampling edge until done rises.
    task automatic sweep(input bit sel, input int inject_at, output int n);
        @(negedge clk);
        if (sel) start3 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start3 = 1'b0;
        n = 0;
        while (n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            start = (n == inject_at);
            if (sel ? done3 : done) break;
        end
        start = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_outputs",
              {27'd0, dut_a, dut_b, busy, done, pass, err_count,
               fail_valid, fail_a, fail_b, fail_c} >> 0, 32'd0);
        rst_n = 1'b1;

        mode = 2'd0;
        sweep(1'b0, -1, edges);
        check("good_edges", edges, 512);
        check("good_err", err_count, 0);
        check("good_pass", pass, 1);
        check("good_fv", fail_valid, 0);
        check("good_a", dut_a, 4'hF);
        check("good_b", dut_b, 4'hF);
        check("good_busy", busy, 0);

        mode = 2'd1;
        sweep(1'b0, -1, edges);
        check("stuck_err", err_count, 192);
        check("stuck_fv", fail_valid, 1);
        check("stuck_fa", fail_a, 4'h0);
        check("stuck_fb", fail_b, 4'h0);
        check("stuck_fc", fail_c, 4'b0001);
        check("stuck_pass", pass, 0);

        mode = 2'd2;
        sweep(1'b0, -1, edges);
        check("zero_err", err_count, 175);
        check("zero_fa", fail_a, 4'h1);
        check("zero_fb", fail_b, 4'h1);
        check("zero_fc", fail_c, 4'h0);
        ec_ref = 9'd175;

        sweep(1'b0, 100, edges);
        check("inject_edges", edges, 512);
        check("inject_err", err_count, ec_ref);

        mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              {27'd0, dut_a, dut_b, busy, done, pass, err_count,
               fail_valid, fail_a, fail_b, fail_c} >> 0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(1'b0, -1, edges);
        check("afterrst_edges", edges, 512);
        check("afterrst_pass", pass, 1);
        check("afterrst_err", err_count, 0);

        mode = 2'd1;
        sweep(1'b0, -1, edges);
        check("rerun_fault_err", err_count, 192);
        mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_clear", {done, fail_valid, err_count}, 11'd0);
        check("restart_busy", busy, 1);
        edges = 0;
        while (edges < 3000 && !done) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check("restart_edges", edges, 512);
        check("restart_pass", pass, 1);

        sweep(1'b1, -1, edges);
        check("settle3_edges", edges, 1024);
        check("settle3_pass", pass3, 1);
        check("settle3_err", ec3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
